// File: rtl/ifns_encoder_iter.sv
// Iterative IFNS crosstalk-avoidance encoder: binary word -> Fibonacci codeword,
// BPC digits resolved per clock, valid/ready handshakes on both sides.
module ifns_encoder_iter #(
  parameter int unsigned DATA_W = 21,
  parameter int unsigned N_OUT  = 30,
  parameter int unsigned BPC    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_code,
  output logic              out_err,
  output logic              busy
);

  localparam int unsigned IDX_W   = $clog2(N_OUT + 1);
  localparam int unsigned CODE_IW = $clog2(N_OUT);
  localparam int unsigned TAB_W   = (N_OUT + 1) * DATA_W;
  localparam int unsigned TAB_IW  = $clog2(TAB_W);

  function automatic longint unsigned fib64(input int unsigned k);
    longint unsigned a, b, t;
    a = 64'd1;
    b = 64'd1;
    for (int unsigned i = 3; i <= k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic logic [TAB_W-1:0] fib_tab();
    logic [TAB_W-1:0] t;
    t = '0;
    for (int unsigned k = 1; k <= N_OUT; k++)
      t[TAB_IW'(k * DATA_W) +: DATA_W] = DATA_W'(fib64(k));
    return t;
  endfunction

  localparam logic [TAB_W-1:0] FIB_TAB = fib_tab();

  // Only weights up to F(N_OUT) take part in comparisons; inputs beyond the
  // encodable maximum are flagged through out_err rather than rejected.
  generate
    if (N_OUT < 3 || BPC < 1 || DATA_W < 2 || DATA_W > 62 ||
        fib64(N_OUT) >= (64'd1 << DATA_W)) begin : g_bad_params
      $error("ifns_encoder_iter: unsupported DATA_W/N_OUT/BPC combination");
    end
  endgenerate

  function automatic logic [DATA_W-1:0] fib_at(input int unsigned k);
    return FIB_TAB[TAB_IW'(k * DATA_W) +: DATA_W];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_rem;
  logic [IDX_W-1:0]   r_idx;
  logic               r_prev;
  logic [N_OUT-1:0]   r_code;
  logic               r_err;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [DATA_W-1:0]  w_rem;
  logic               w_prev;
  logic [N_OUT-1:0]   w_code;
  logic               w_err;
  logic               w_last;

  // BPC chained digit stages; r_idx counts digits already resolved, MSB first.
  always_comb begin
    int unsigned k;
    logic        d;
    k      = 0;
    d      = 1'b0;
    w_rem  = r_rem;
    w_prev = r_prev;
    w_code = r_code;
    w_err  = r_err;
    for (int unsigned s = 0; s < BPC; s++) begin
      k = 0;
      d = 1'b0;
      if (32'(r_idx) + s < N_OUT) begin
        k = N_OUT - 32'(r_idx) - s;
        if (k == 1) begin
          d     = w_rem[0];
          w_err = |w_rem[DATA_W-1:1];
        end else begin
          if (k == N_OUT)                  d = (w_rem >= fib_at(k));
          else if (w_rem >= fib_at(k + 1)) d = 1'b1;
          else if (w_rem <  fib_at(k))     d = 1'b0;
          else                             d = w_prev;
          if (d) w_rem = w_rem - fib_at(k);
        end
        w_code[CODE_IW'(k - 1)] = d;
        w_prev = d;
      end
    end
  end

  assign w_last = (32'(r_idx) + BPC >= N_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_idx       <= '0;
      r_prev      <= 1'b0;
      r_code      <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rem      <= in_data;
            r_idx      <= '0;
            r_prev     <= 1'b0;
            r_code     <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_rem  <= w_rem;
          r_prev <= w_prev;
          r_code <= w_code;
          r_err  <= w_err;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(BPC);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_code  = r_code;
  assign out_err   = r_err;
  assign busy      = r_busy;

endmodule
